battle_turn_controller: RTL and testbench

- Top-level turn sequencer for the battle screen.
- Alternates the player action phase (menu) with the enemy bullet wave.
- After each wave, it pulses the 8-slot bullet damage scanner, waits for its completion strobe and subtracts the accumulated damage from player HP.
- It owns both HP registers and declares win/lose; the renderer and bullet spawner read its phase outputs.

---
 rtl/battle_pkg.sv | 26 ++
 rtl/sat_sub.sv | 20 ++
 rtl/battle_turn_controller.sv | 179 +++++++++++++++++
 tb/tb_battle_turn_controller.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/battle_pkg.sv
// Shared battle-screen definitions: phase encoding and HP defaults.
// The renderer and HUD read the same constants.
package battle_pkg;

    localparam int HP_W = 8;

    localparam logic [HP_W-1:0] PLAYER_HP_DEFAULT = 8'd100;
    localparam logic [HP_W-1:0] ENEMY_HP_DEFAULT  = 8'd200;

    typedef enum logic [2:0] {
        PH_IDLE      = 3'd0,
        PH_MENU      = 3'd1,
        PH_P_ATK     = 3'd2,
        PH_WAVE      = 3'd3,
        PH_SCAN_REQ  = 3'd4,
        PH_SCAN_WAIT = 3'd5,
        PH_WIN       = 3'd6,
        PH_LOSE      = 3'd7
    } phase_t;

    // Saturating increment for 8-bit event counters.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sat_sub.sv
// Unsigned saturating subtractor: y = max(a - b, 0).
// The borrow out of a 9-bit difference selects the clamp.
module sat_sub
    import battle_pkg::*;
(
    input  logic [HP_W-1:0] a,
    input  logic [HP_W-1:0] b,
    output logic [HP_W-1:0] y,
    output logic            zero
);

    logic [HP_W:0] diff;

    always_comb begin
        diff = {1'b0, a} - {1'b0, b};
        y    = diff[HP_W] ? '0 : diff[HP_W-1:0];
        zero = (y == '0);
    end

endmodule

// File: rtl/battle_turn_controller.sv
// Turn sequencer for the battle screen: player menu, enemy bullet wave,
// damage scan, HP bookkeeping and win/lose detection.
module battle_turn_controller
    import battle_pkg::*;
#(
    parameter logic [7:0] PLAYER_HP_MAX = PLAYER_HP_DEFAULT,
    parameter logic [7:0] ENEMY_HP_MAX  = ENEMY_HP_DEFAULT,
    parameter int         WAVE_CYCLES   = 1024,
    parameter int         SCAN_TIMEOUT  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_start,
    input  logic       act_valid,
    input  logic       act_fight,
    input  logic [7:0] act_power,
    output logic       act_ready,
    output logic       wave_active,
    output logic       scan_start,
    input  logic       scan_done,
    input  logic [7:0] scan_damage,
    output logic [7:0] player_hp,
    output logic [7:0] enemy_hp,
    output logic [2:0] phase,
    output logic       win,
    output logic       lose,
    output logic [7:0] turn_count,
    output logic       scan_err
);

    localparam logic [2:0] S_IDLE      = 3'(PH_IDLE);
    localparam logic [2:0] S_MENU      = 3'(PH_MENU);
    localparam logic [2:0] S_P_ATK     = 3'(PH_P_ATK);
    localparam logic [2:0] S_WAVE      = 3'(PH_WAVE);
    localparam logic [2:0] S_SCAN_REQ  = 3'(PH_SCAN_REQ);
    localparam logic [2:0] S_SCAN_WAIT = 3'(PH_SCAN_WAIT);
    localparam logic [2:0] S_WIN       = 3'(PH_WIN);
    localparam logic [2:0] S_LOSE      = 3'(PH_LOSE);

    localparam int WAVE_W = (WAVE_CYCLES  > 1) ? $clog2(WAVE_CYCLES)  : 1;
    localparam int TMO_W  = (SCAN_TIMEOUT > 1) ? $clog2(SCAN_TIMEOUT) : 1;
    localparam logic [WAVE_W-1:0] WAVE_LAST = WAVE_W'(WAVE_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SCAN_TIMEOUT - 1);

    logic [2:0]        state_reg,      state_next;
    logic [7:0]        player_hp_reg,  player_hp_next;
    logic [7:0]        enemy_hp_reg,   enemy_hp_next;
    logic [7:0]        turn_count_reg, turn_count_next;
    logic              scan_err_reg,   scan_err_next;
    logic              act_fight_reg,  act_fight_next;
    logic [7:0]        act_power_reg,  act_power_next;
    logic [WAVE_W-1:0] wave_cnt_reg,   wave_cnt_next;
    logic [TMO_W-1:0]  tmo_cnt_reg,    tmo_cnt_next;

    logic [7:0] enemy_hp_sub;
    logic       enemy_hp_zero;
    logic [7:0] player_hp_sub;
    logic       player_hp_zero;

    sat_sub u_enemy_sub (
        .a    (enemy_hp_reg),
        .b    (act_power_reg),
        .y    (enemy_hp_sub),
        .zero (enemy_hp_zero)
    );

    sat_sub u_player_sub (
        .a    (player_hp_reg),
        .b    (scan_damage),
        .y    (player_hp_sub),
        .zero (player_hp_zero)
    );

    always_comb begin
        state_next      = state_reg;
        player_hp_next  = player_hp_reg;
        enemy_hp_next   = enemy_hp_reg;
        turn_count_next = turn_count_reg;
        scan_err_next   = scan_err_reg;
        act_fight_next  = act_fight_reg;
        act_power_next  = act_power_reg;
        wave_cnt_next   = wave_cnt_reg;
        tmo_cnt_next    = tmo_cnt_reg;

        case (state_reg)
            S_IDLE, S_WIN, S_LOSE: begin
                if (game_start) begin
                    state_next      = S_MENU;
                    player_hp_next  = PLAYER_HP_MAX;
                    enemy_hp_next   = ENEMY_HP_MAX;
                    turn_count_next = 8'd0;
                    scan_err_next   = 1'b0;
                end
            end
            S_MENU: begin
                if (act_valid) begin
                    act_fight_next = act_fight;
                    act_power_next = act_power;
                    state_next     = S_P_ATK;
                end
            end
            S_P_ATK: begin
                wave_cnt_next = '0;
                if (act_fight) begin
                    state_next = S_WAVE;
                end
                if (act_fight_reg) begin
                    enemy_hp_next = enemy_hp_sub;
                    state_next    = enemy_hp_zero ? S_WIN : S_WAVE;
                end else begin
                    state_next = S_WAVE;
                end
            end
            S_WAVE: begin
                if (wave_cnt_reg == WAVE_LAST) begin
                    state_next = S_SCAN_REQ;
                end else begin
                    wave_cnt_next = wave_cnt_reg + 1'b1;
                end
            end
            S_SCAN_REQ: begin
                tmo_cnt_next = '0;
                state_next   = S_SCAN_WAIT;
            end
            S_SCAN_WAIT: begin
                // A completion strobe in the final timeout cycle still counts as a real scan.
                if (scan_done) begin
                    player_hp_next  = player_hp_sub;
                    turn_count_next = sat_inc8(turn_count_reg);
                    state_next      = player_hp_zero ? S_LOSE : S_MENU;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    scan_err_next   = 1'b1;
                    turn_count_next = sat_inc8(turn_count_reg);
                    state_next      = S_MENU;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            player_hp_reg  <= 8'd0;
            enemy_hp_reg   <= 8'd0;
            turn_count_reg <= 8'd0;
            scan_err_reg   <= 1'b0;
            act_fight_reg  <= 1'b0;
            act_power_reg  <= 8'd0;
            wave_cnt_reg   <= '0;
            tmo_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            player_hp_reg  <= player_hp_next;
            enemy_hp_reg   <= enemy_hp_next;
            turn_count_reg <= turn_count_next;
            scan_err_reg   <= scan_err_next;
            act_fight_reg  <= act_fight_next;
            act_power_reg  <= act_power_next;
            wave_cnt_reg   <= wave_cnt_next;
            tmo_cnt_reg    <= tmo_cnt_next;
        end
    end

    // Phase flags decode straight from the state register, so reset clears them at once.
    assign act_ready   = (state_reg == S_MENU);
    assign wave_active = (state_reg == S_WAVE);
    assign scan_start  = (state_reg == S_SCAN_REQ);
    assign win         = (state_reg == S_WIN);
    assign lose        = (state_reg == S_LOSE);
    assign phase       = state_reg;
    assign player_hp   = player_hp_reg;
    assign enemy_hp    = enemy_hp_reg;
    assign turn_count  = turn_count_reg;
    assign scan_err    = scan_err_reg;

endmodule

// File: tb/tb_battle_turn_controller.sv
// Directed bench for battle_turn_controller with short wave/timeout lengths.
module tb_battle_turn_controller;

    localparam int WC = 16;
    localparam int TO = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       game_start = 1'b0;
    logic       act_valid = 1'b0;
    logic       act_fight = 1'b0;
    logic [7:0] act_power = 8'd0;
    logic       act_ready;
    logic       wave_active;
    logic       scan_start;
    logic       scan_done = 1'b0;
    logic [7:0] scan_damage = 8'd0;
    logic [7:0] player_hp;
    logic [7:0] enemy_hp;
    logic [2:0] phase;
    logic       win;
    logic       lose;
    logic [7:0] turn_count;
    logic       scan_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    battle_turn_controller #(
        .PLAYER_HP_MAX (8'd100),
        .ENEMY_HP_MAX  (8'd200),
        .WAVE_CYCLES   (WC),
        .SCAN_TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .game_start  (game_start),
        .act_valid   (act_valid),
        .act_fight   (act_fight),
        .act_power   (act_power),
        .act_ready   (act_ready),
        .wave_active (wave_active),
        .scan_start  (scan_start),
        .scan_done   (scan_done),
        .scan_damage (scan_damage),
        .player_hp   (player_hp),
        .enemy_hp    (enemy_hp),
        .phase       (phase),
        .win         (win),
        .lose        (lose),
        .turn_count  (turn_count),
        .scan_err    (scan_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until phase leaves ph (bounded); n = cycles spent in ph, pulses = scan_start seen.
    task automatic run_phase(input logic [2:0] ph, output int n, output int pulses);
        n = 0;
        pulses = 0;
        while (phase == ph && n < 4 * WC) begin
            if (scan_start) pulses++;
            n++;
            step();
        end
    endtask

    task automatic start_game();
        game_start = 1'b1;
        step();
        game_start = 1'b0;
    endtask

    task automatic do_action(input logic fight, input logic [7:0] pwr);
        act_valid = 1'b1;
        act_fight = fight;
        act_power = pwr;
        step();
        act_valid = 1'b0;
        act_fight = 1'b0;
        act_power = 8'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({phase, player_hp, enemy_hp, turn_count} !== 27'd0 ||
            {act_ready, wave_active, scan_start, win, lose, scan_err} !== 6'd0) begin
            errors++;
            $display("FAIL reset_state: phase=%0d php=%0d ehp=%0d turns=%0d flags=%b required all zero",
                     phase, player_hp, enemy_hp, turn_count,
                     {act_ready, wave_active, scan_start, win, lose, scan_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        $display("reset: phase=%0d", phase);
    endtask

    task automatic test_start();
        start_game();
        checks++;
        if (phase !== 3'd1 || player_hp !== 8'd100 || enemy_hp !== 8'd200 ||
            act_ready !== 1'b1 || turn_count !== 8'd0) begin
            errors++;
            $display("FAIL start: phase=%0d php=%0d ehp=%0d rdy=%b turns=%0d required 1/100/200/1/0",
                     phase, player_hp, enemy_hp, act_ready, turn_count);
        end
        $display("start: phase=%0d php=%0d ehp=%0d", phase, player_hp, enemy_hp);
    endtask

    task automatic test_fight_wave_lose();
        int n, p;
        do_action(1'b1, 8'd50);
        checks++;
        if (phase !== 3'd2 || enemy_hp !== 8'd200 || act_ready !== 1'b0) begin
            errors++;
            $display("FAIL p_atk: phase=%0d ehp=%0d rdy=%b required 2/200/0", phase, enemy_hp, act_ready);
        end
        step();
        checks++;
        if (enemy_hp !== 8'd150 || phase !== 3'd3) begin
            errors++;
            $display("FAIL enemy_dmg: ehp=%0d phase=%0d required 150/3", enemy_hp, phase);
        end
        run_phase(3'd3, n, p);
        checks++;
        if (n !== WC || p !== 0) begin
            errors++;
            $display("FAIL wave_len: cycles=%0d pulses=%0d required %0d/0", n, p, WC);
        end
        run_phase(3'd4, n, p);
        checks++;
        if (n !== 1 || p !== 1 || phase !== 3'd5 || scan_start !== 1'b0) begin
            errors++;
            $display("FAIL scan_req: cycles=%0d pulses=%0d phase=%0d required 1/1/5", n, p, phase);
        end
        scan_done = 1'b1;
        scan_damage = 8'd150;
        step();
        scan_done = 1'b0;
        scan_damage = 8'd0;
        checks++;
        if (player_hp !== 8'd0 || lose !== 1'b1 || phase !== 3'd7 || turn_count !== 8'd1) begin
            errors++;
            $display("FAIL lose: php=%0d lose=%b phase=%0d turns=%0d required 0/1/7/1",
                     player_hp, lose, phase, turn_count);
        end
        $display("fight_wave_lose: ehp=%0d php=%0d phase=%0d", enemy_hp, player_hp, phase);
    endtask

    task automatic test_skip_scan();
        int n, p;
        start_game();
        do_action(1'b0, 8'd77);
        step();
        checks++;
        if (enemy_hp !== 8'd200 || phase !== 3'd3) begin
            errors++;
            $display("FAIL skip: ehp=%0d phase=%0d required 200/3", enemy_hp, phase);
        end
        run_phase(3'd3, n, p);
        step();
        scan_done = 1'b1;
        scan_damage = 8'd30;
        step();
        scan_done = 1'b0;
        checks++;
        if (player_hp !== 8'd70 || phase !== 3'd1 || turn_count !== 8'd1 || scan_err !== 1'b0) begin
            errors++;
            $display("FAIL scan_hit: php=%0d phase=%0d turns=%0d err=%b required 70/1/1/0",
                     player_hp, phase, turn_count, scan_err);
        end
        game_start = 1'b1;
        step();
        game_start = 1'b0;
        checks++;
        if (player_hp !== 8'd70 || phase !== 3'd1) begin
            errors++;
            $display("FAIL start_in_menu: php=%0d phase=%0d required 70/1", player_hp, phase);
        end
        $display("skip_scan: php=%0d turns=%0d", player_hp, turn_count);
    endtask

    task automatic test_win();
        int n;
        do_action(1'b1, 8'd250);
        step();
        checks++;
        if (enemy_hp !== 8'd0 || win !== 1'b1 || phase !== 3'd6) begin
            errors++;
            $display("FAIL win: ehp=%0d win=%b phase=%0d required 0/1/6", enemy_hp, win, phase);
        end
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (wave_active || scan_start || phase !== 3'd6) n++;
            step();
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL win_hold: bad_cycles=%0d required 0", n);
        end
        $display("win: ehp=%0d phase=%0d", enemy_hp, phase);
    endtask

    task automatic test_simultaneous();
        int n, p;
        start_game();
        do_action(1'b0, 8'd0);
        step();
        run_phase(3'd3, n, p);
        step();
        for (int i = 0; i < TO - 1; i++) step();
        scan_done = 1'b1;
        scan_damage = 8'd10;
        step();
        scan_done = 1'b0;
        checks++;
        if (player_hp !== 8'd90 || phase !== 3'd1 || scan_err !== 1'b0 || turn_count !== 8'd1) begin
            errors++;
            $display("FAIL done_at_timeout: php=%0d phase=%0d err=%b turns=%0d required 90/1/0/1",
                     player_hp, phase, scan_err, turn_count);
        end
        $display("simultaneous: php=%0d err=%b", player_hp, scan_err);
    endtask

    task automatic test_timeout();
        int n, p;
        do_action(1'b0, 8'd0);
        step();
        run_phase(3'd3, n, p);
        step();
        run_phase(3'd5, n, p);
        checks++;
        if (n !== TO || scan_err !== 1'b1 || player_hp !== 8'd90 || phase !== 3'd1 || turn_count !== 8'd2) begin
            errors++;
            $display("FAIL timeout: wait=%0d err=%b php=%0d phase=%0d turns=%0d required %0d/1/90/1/2",
                     n, scan_err, player_hp, phase, turn_count, TO);
        end
        scan_done = 1'b1;
        scan_damage = 8'd40;
        step();
        scan_done = 1'b0;
        checks++;
        if (player_hp !== 8'd90 || phase !== 3'd1 || turn_count !== 8'd2) begin
            errors++;
            $display("FAIL done_in_menu: php=%0d phase=%0d turns=%0d required 90/1/2",
                     player_hp, phase, turn_count);
        end
        $display("timeout: err=%b php=%0d", scan_err, player_hp);
    endtask

    task automatic test_reset_mid_wave();
        do_action(1'b0, 8'd0);
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({phase, player_hp, enemy_hp, turn_count} !== 27'd0 ||
            {act_ready, wave_active, scan_start, win, lose, scan_err} !== 6'd0) begin
            errors++;
            $display("FAIL reset_mid_wave: phase=%0d php=%0d ehp=%0d flags=%b required all zero",
                     phase, player_hp, enemy_hp,
                     {act_ready, wave_active, scan_start, win, lose, scan_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        start_game();
        checks++;
        if (phase !== 3'd1 || player_hp !== 8'd100 || enemy_hp !== 8'd200 ||
            turn_count !== 8'd0 || scan_err !== 1'b0) begin
            errors++;
            $display("FAIL restart: phase=%0d php=%0d ehp=%0d turns=%0d err=%b required 1/100/200/0/0",
                     phase, player_hp, enemy_hp, turn_count, scan_err);
        end
        $display("reset_mid_wave: phase=%0d php=%0d", phase, player_hp);
    endtask

    initial begin
        test_reset();
        test_start();
        test_fight_wave_lose();
        test_skip_scan();
        test_win();
        test_simultaneous();
        test_timeout();
        test_reset_mid_wave();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
